// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux_sched sequencing controller.
package demux_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Round-robin successor; wraps at n-1 so non-power-of-2 output counts work.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr == n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/demux_sched_rr_ptr.sv
// Round-robin destination pointer; ptr_next is the post-advance value so a
// beat captured in the same cycle as a completion sees the advanced pointer.
module demux_sched_rr_ptr
   import demux_sched_pkg::*;
#(
   parameter int  N_OUT = 4,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] ptr_next
);

   always_comb begin
      ptr_next = ptr;
      if (adv) ptr_next = SEL_W'(rr_next(32'(ptr), N_OUT));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_next;
   end

endmodule

// File: rtl/demux_sched.sv
// 1:N_OUT DEMUX sequencing controller: holds one beat and steers it by tag or
// round-robin. Optional per-output transfer counters under DEMUX_SCHED_CNT_EN.
module demux_sched
   import demux_sched_pkg::*;
#(
   parameter int  N_OUT = 4,
   parameter int  DW    = 8,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   input  logic [SEL_W-1:0]   in_dest,
   output logic [SEL_W-1:0]   sel,
   output logic [DW-1:0]      out_data,
   output logic [N_OUT-1:0]   out_valid,
   input  logic [N_OUT-1:0]   out_ready,
   output logic               dest_err,
   output logic               busy,
   output logic [N_OUT*CNT_W-1:0] xfer_cnt
);

   // Handshakes: a beat moves on in_valid & in_ready, and leaves on
   // out_valid[sel] & out_ready[sel]; ready on unselected outputs is ignored.
   state_t           state_q, state_d;
   logic [DW-1:0]    data_q;
   logic [SEL_W-1:0] sel_q;
   logic             mode_q;
   logic             err_q;
   logic             done, take, eff_mode, dest_ok, bad, load, adv;
   logic [SEL_W-1:0] ptr, ptr_next, next_dest;

   assign done      = (state_q == HOLD) && out_ready[sel_q];
   assign take      = in_valid && in_ready;
   assign eff_mode  = (state_q == HOLD) ? mode_q : mode;
   assign dest_ok   = (int'(in_dest) < N_OUT);
   assign bad       = take && !eff_mode && !dest_ok;
   assign load      = take && !bad;
   assign adv       = done && mode_q;
   assign next_dest = eff_mode ? ptr_next : in_dest;

   demux_sched_rr_ptr #(.N_OUT(N_OUT)) u_rr_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .ptr      (ptr),
      .ptr_next (ptr_next)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = '0;
      case (state_q)
         IDLE: begin
            in_ready = rst_n;
            if (load) state_d = HOLD;
         end
         HOLD: begin
            busy             = 1'b1;
            out_valid[sel_q] = 1'b1;
            in_ready         = rst_n && out_ready[sel_q];
            if (load)      state_d = HOLD;
            else if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= bad;
         // Mode is only re-latched on a capture from IDLE.
         if (state_q == IDLE && in_valid) mode_q <= mode;
         if (load) begin
            data_q <= in_data;
            sel_q  <= next_dest;
         end
      end
   end

   assign sel      = sel_q;
   assign out_data = data_q;
   assign dest_err = err_q;

`ifdef DEMUX_SCHED_CNT_EN
   for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk) begin
         if (!rst_n)
            cnt_q <= '0;
         else if (done && sel_q == SEL_W'(i) && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_W'(1);
      end
      assign xfer_cnt[CNT_W*i +: CNT_W] = cnt_q;
   end
`else
   assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: an N_OUT=4 and an N_OUT=3 instance share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_demux_sched;

   logic       clk = 1'b0;
   logic       rst_n, mode, in_valid;
   logic [7:0] in_data;
   logic [1:0] in_dest;
   logic [3:0] out_ready;

   logic        a_in_ready, a_dest_err, a_busy;
   logic [1:0]  a_sel;
   logic [7:0]  a_out_data;
   logic [3:0]  a_out_valid;
   logic [63:0] a_xfer_cnt;

   logic        b_in_ready, b_dest_err, b_busy;
   logic [1:0]  b_sel;
   logic [7:0]  b_out_data;
   logic [2:0]  b_out_valid;
   logic [47:0] b_xfer_cnt;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

`ifdef DEMUX_SCHED_CNT_EN
   localparam int CNT2 = 2;
`else
   localparam int CNT2 = 0;
`endif

   // clock / reset
   always #5 clk = ~clk;

   demux_sched #(.N_OUT(4), .DW(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
      .in_ready(a_in_ready), .in_data(in_data), .in_dest(in_dest),
      .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(out_ready), .dest_err(a_dest_err), .busy(a_busy),
      .xfer_cnt(a_xfer_cnt)
   );

   demux_sched #(.N_OUT(3), .DW(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
      .in_ready(b_in_ready), .in_data(in_data), .in_dest(in_dest),
      .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(out_ready[2:0]), .dest_err(b_dest_err), .busy(b_busy),
      .xfer_cnt(b_xfer_cnt)
   );

   // Model: per instance k (0: four outputs, 1: three outputs) track whether a
   // beat is held, its payload/destination, the rr pointer and counters.
   bit         m_hold [2];
   logic [7:0] m_data [2];
   logic [1:0] m_sel  [2];
   int         m_ptr  [2];
   bit         m_mode [2];
   bit         m_err  [2];
   int         m_cnt  [2][4];
   bit         t_done, t_take, t_em, t_bad;
   int         t_n, t_pn;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         t_n = (k == 0) ? 4 : 3;
         if (!rst_n) begin
            m_hold[k] = 0; m_data[k] = 8'h00; m_sel[k] = 2'd0;
            m_ptr[k] = 0; m_mode[k] = 0; m_err[k] = 0;
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
         end else begin
            t_done = m_hold[k] && out_ready[m_sel[k]];
            t_take = in_valid && (!m_hold[k] || t_done);
            t_em   = m_hold[k] ? m_mode[k] : mode;
            t_pn   = (t_done && m_mode[k]) ? (m_ptr[k] + 1) % t_n : m_ptr[k];
            t_bad  = t_take && !t_em && (int'(in_dest) >= t_n);
            if (t_done && m_cnt[k][m_sel[k]] < 65535) m_cnt[k][m_sel[k]]++;
            if (!m_hold[k] && in_valid) m_mode[k] = mode;
            m_ptr[k] = t_pn;
            m_err[k] = t_bad;
            if (t_take && !t_bad) begin
               m_hold[k] = 1;
               m_data[k] = in_data;
               m_sel[k]  = t_em ? 2'(t_pn) : in_dest;
            end else if (t_done || t_bad) begin
               m_hold[k] = 0;
            end
         end
      end
   end

   // Scoreboard compare on the falling edge, every cycle once reset has run.
   logic [80:0] exp_a, got_a;
   logic [63:0] exp_b, got_b;
   logic [63:0] ec_a;
   logic [47:0] ec_b;

   always @(negedge clk) begin
      if (chk_en) begin
         ec_a = '0;
         ec_b = '0;
`ifdef DEMUX_SCHED_CNT_EN
         for (int i = 0; i < 4; i++) ec_a[16*i +: 16] = 16'(m_cnt[0][i]);
         for (int i = 0; i < 3; i++) ec_b[16*i +: 16] = 16'(m_cnt[1][i]);
`endif
         exp_a = {rst_n && (!m_hold[0] || out_ready[m_sel[0]]),
                  (m_hold[0] ? (4'b0001 << m_sel[0]) : 4'b0000),
                  m_sel[0], m_data[0], m_err[0], m_hold[0], ec_a};
         got_a = {a_in_ready, a_out_valid, a_sel, a_out_data, a_dest_err, a_busy, a_xfer_cnt};
         exp_b = {rst_n && (!m_hold[1] || out_ready[m_sel[1]]),
                  (m_hold[1] ? (3'b001 << m_sel[1]) : 3'b000),
                  m_sel[1], m_data[1], m_err[1], m_hold[1], ec_b};
         got_b = {b_in_ready, b_out_valid, b_sel, b_out_data, b_dest_err, b_busy, b_xfer_cnt};
         n_total += 2;
         if (got_a === exp_a) n_pass++;
         else $display("FAIL model_a t=%0t got %h expected %h", $time, got_a, exp_a);
         if (got_b === exp_b) n_pass++;
         else $display("FAIL model_b t=%0t got %h expected %h", $time, got_b, exp_b);
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %0h expected %0h", name, act, exp);
   endtask

   int sa [5] = '{0, 1, 2, 3, 0};
   int sb [5] = '{0, 1, 2, 0, 1};

   initial begin
      rst_n = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
      in_dest = 2'd1; out_ready = 4'hF;
      cyc();
      chk_en = 1'b1;
      cyc();
      check("rst_out_valid", 64'(a_out_valid), 0);
      check("rst_sel",       64'(a_sel), 0);
      check("rst_out_data",  64'(a_out_data), 0);
      check("rst_busy_err",  64'({a_busy, a_dest_err, b_busy, b_dest_err}), 0);
      check("rst_in_ready",  64'({a_in_ready, b_in_ready}), 0);
      check("rst_xfer_cnt",  a_xfer_cnt, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", 64'({a_in_ready, b_in_ready}), 64'b11);

      // directed, back-to-back
      in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2;
      cyc();
      check("dir1_valid", 64'(a_out_valid), 64'b0100);
      check("dir1_data",  64'(a_out_data), 64'hA5);
      check("dir1_ready", 64'(a_in_ready), 1);
      in_data = 8'h3C; in_dest = 2'd0;
      cyc();
      check("dir2_valid", 64'(a_out_valid), 64'b0001);
      check("dir2_data",  64'(a_out_data), 64'h3C);
      check("dir2_b_valid", 64'(b_out_valid), 64'b001);
      in_valid = 1'b0;
      cyc();
      check("dir_idle", 64'({a_busy, a_out_valid}), 0);

      // backpressure on output 1
      out_ready = 4'b1101; in_valid = 1'b1; in_data = 8'h5A; in_dest = 2'd1;
      cyc();
      in_valid = 1'b0; in_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 64'(a_out_valid), 64'b0010);
         check("bp_data",  64'(a_out_data), 64'h5A);
         check("bp_ready", 64'({a_in_ready, b_in_ready}), 0);
         cyc();
      end
      out_ready = 4'hF;
      #1;
      check("bp_release_ready", 64'(a_in_ready), 1);
      cyc();
      check("bp_done_idle", 64'({a_busy, a_out_valid}), 0);

      // round-robin; mode pin and in_dest change while holding are ignored
      mode = 1'b1; in_valid = 1'b1; in_dest = 2'd3;
      for (int j = 0; j < 5; j++) begin
         in_data = 8'(8'h10 + j);
         cyc();
         if (j == 0) mode = 1'b0;
         check("rr_sel_a", 64'(a_sel), 64'(sa[j]));
         check("rr_sel_b", 64'(b_sel), 64'(sb[j]));
      end
      in_valid = 1'b0;
      cyc();

      // invalid destination from IDLE
      mode = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd3;
      cyc();
      in_valid = 1'b0;
      check("bad_b_err",   64'(b_dest_err), 1);
      check("bad_b_idle",  64'({b_busy, b_out_valid}), 0);
      check("bad_a_valid", 64'(a_out_valid), 64'b1000);
      cyc();
      check("bad_b_err_pulse", 64'(b_dest_err), 0);

      // invalid destination captured in the completion cycle
      in_valid = 1'b1; in_data = 8'h11; in_dest = 2'd1;
      cyc();
      in_data = 8'h22; in_dest = 2'd3;
      cyc();
      in_valid = 1'b0;
      check("hold_bad_b", 64'({b_dest_err, b_busy}), 64'b10);
      check("hold_bad_a", 64'({a_out_valid, a_out_data}), 64'h822);
      cyc();

      // random traffic, checked by the model
      for (int i = 0; i < 300; i++) begin
         mode      = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         in_dest   = 2'($urandom_range(0, 3));
         out_ready = 4'($urandom_range(0, 15));
         cyc();
      end
      in_valid = 1'b0; out_ready = 4'hF;
      cyc();
      cyc();

      // counters, then reset while holding
      rst_n = 1'b0; mode = 1'b0;
      cyc();
      rst_n = 1'b1; in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h01;
      cyc();
      in_data = 8'h02;
      cyc();
      in_valid = 1'b0;
      cyc();
      check("cnt_two", 64'(a_xfer_cnt[15:0]), 64'(CNT2));
      in_valid = 1'b1; in_data = 8'h03; out_ready = 4'h0;
      cyc();
      in_valid = 1'b0;
      check("cnt_hold_busy", 64'(a_busy), 1);
      check("cnt_hold_val",  64'(a_xfer_cnt[15:0]), 64'(CNT2));
      rst_n = 1'b0;
      cyc();
      check("midrst_cnt",   a_xfer_cnt, 0);
      check("midrst_valid", 64'({a_out_valid, b_out_valid, a_busy}), 0);
      rst_n = 1'b1; out_ready = 4'hF;
      cyc();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
